iq_framer: RTL and testbench

IQ_FRAMER -- requirements
Module: iq_framer

---
 rtl/iq_framer.sv | 165 ++++++++++++++++
 tb/tb_iq_framer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_framer.sv
// Packs I/Q samples into frames of {SYNC,cnt} header, FRAME_LEN payload words and XOR trailer.
// The header appears one cycle after the FIFO reaches FRAME_LEN; out_ready stalls only the output side, and input overflow is counted.
module iq_framer #(
  parameter int          FRAME_LEN = 64,
  parameter int          FIFO_AW   = 8,
  parameter logic [15:0] SYNC      = 16'hA55A
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [15:0]        ovf_cnt,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                DEPTH    = 1 << FIFO_AW;
  localparam int                CW       = $clog2(FRAME_LEN);
  localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]  LVL_FRM  = (FIFO_AW+1)'(FRAME_LEN);
  localparam logic [CW-1:0]     PAY_LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [31:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic [FIFO_AW-1:0]   rd_ptr_p1;
  logic [31:0]          head;
  logic [31:0]          head_nxt;
  logic [CW-1:0]        pay_cnt;
  logic [15:0]          frame_cnt;
  logic [15:0]          hdr_cnt;
  logic [31:0]          acc;
  logic                 full;
  logic                 wr_en;
  logic                 xfer;
  logic                 start;
  logic                 pay_last;
  logic                 ld_hdr;
  logic                 ld_first;
  logic                 ld_next;
  logic                 ld_trl;
  logic                 pop;
  logic                 go_idle;
  logic                 frm_done;

  assign full      = (fifo_level == LVL_FULL);
  assign wr_en     = in_valid && !full;
  assign xfer      = out_valid && out_ready;
  assign start     = (fifo_level >= LVL_FRM);
  assign pay_last  = (pay_cnt == PAY_LAST);
  assign rd_ptr_p1 = rd_ptr + FIFO_AW'(1);
  // A payload word stays in the FIFO while presented; the register looks one entry ahead.
  assign head      = mem[rd_ptr];
  assign head_nxt  = mem[rd_ptr_p1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HEADER;
      HEADER:  if (xfer) state_nxt = PAYLOAD;
      PAYLOAD: if (xfer && pay_last) state_nxt = TRAILER;
      TRAILER: if (xfer) state_nxt = start ? HEADER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_hdr   = 1'b0;
    ld_first = 1'b0;
    ld_next  = 1'b0;
    ld_trl   = 1'b0;
    pop      = 1'b0;
    go_idle  = 1'b0;
    frm_done = 1'b0;
    hdr_cnt  = frame_cnt;
    case (state)
      IDLE:    ld_hdr = start;
      HEADER:  ld_first = xfer;
      PAYLOAD: begin
        pop     = xfer;
        ld_next = xfer && !pay_last;
        ld_trl  = xfer && pay_last;
      end
      TRAILER: begin
        frm_done = xfer;
        ld_hdr   = xfer && start;
        go_idle  = xfer && !start;
        hdr_cnt  = frame_cnt + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // Full check uses the pre-edge level, so a same-edge pop never rescues a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr_p1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      acc       <= '0;
      pay_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      if (ld_hdr) begin
        out_data  <= {SYNC, hdr_cnt};
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end
      if (ld_first) begin
        out_data <= head;
        acc      <= head;
        pay_cnt  <= '0;
      end
      if (ld_next) begin
        out_data <= head_nxt;
        acc      <= acc ^ head_nxt;
        pay_cnt  <= pay_cnt + CW'(1);
      end
      if (ld_trl) begin
        out_data <= acc;
        out_last <= 1'b1;
      end
      if (go_idle) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (frm_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_iq_framer.sv
// Bench for iq_framer (FRAME_LEN=4, FIFO_AW=3): vector table, corner sequences, and random traffic vs a queue model.
module tb_iq_framer;

  localparam int          FL    = 4;
  localparam int          AW    = 3;
  localparam int          DEPTH = 8;
  localparam logic [15:0] SYNC  = 16'hA55A;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] ovf_cnt;
  logic [AW:0] fifo_level;

  iq_framer #(.FRAME_LEN(FL), .FIFO_AW(AW), .SYNC(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .ovf_cnt(ovf_cnt), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: sample queue plus the word list of the frame in flight.
  logic [31:0] m_fifo [$];
  logic [31:0] m_frm  [$];
  bit          m_act;
  int          m_idx;
  logic [15:0] m_fcnt;
  logic [15:0] m_ovf;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  elv;
  } vec_t;

  vec_t        tbl [$];
  logic [31:0] got [$];
  logic [31:0] exp_w [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_frm.delete();
    m_act  = 0;
    m_idx  = 0;
    m_fcnt = 16'd0;
    m_ovf  = 16'd0;
  endtask

  task automatic model_step(input logic iv, input logic [31:0] id, input logic rdy);
    int          pre;
    logic [31:0] x;
    pre = m_fifo.size();
    if (m_act && rdy) begin
      if (m_idx >= 1 && m_idx <= FL) void'(m_fifo.pop_front());
      if (m_idx == FL + 1) begin
        m_act  = 0;
        m_fcnt = m_fcnt + 16'd1;
      end else begin
        m_idx++;
      end
    end
    if (!m_act && pre >= FL) begin
      m_frm.delete();
      m_frm.push_back({SYNC, m_fcnt});
      x = 32'd0;
      for (int i = 0; i < FL; i++) begin
        m_frm.push_back(m_fifo[i]);
        x ^= m_fifo[i];
      end
      m_frm.push_back(x);
      m_idx = 0;
      m_act = 1;
    end
    if (iv) begin
      if (pre == DEPTH) begin
        if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      end else begin
        m_fifo.push_back(id);
      end
    end
  endtask

  task automatic model_cmp();
    chk("model_valid", 32'(out_valid), 32'(m_act));
    chk("model_last", 32'(out_last), 32'(m_act && m_idx == FL + 1));
    chk("model_level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("model_ovf", 32'(ovf_cnt), 32'(m_ovf));
    if (m_act) chk("model_data", out_data, m_frm[m_idx]);
  endtask

  // Called at a falling edge: drive, take one rising edge, step model, check at next falling edge.
  task automatic cyc(input logic iv, input logic [31:0] id, input logic rdy);
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    @(posedge clk);
    model_step(iv, id, rdy);
    @(negedge clk);
    model_cmp();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(logic iv, logic [31:0] id, logic rdy,
                              logic ev, logic [31:0] ed, logic el, logic [3:0] elv);
    vec_t t;
    t.iv = iv; t.id = id; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.el = el; t.elv = elv;
    return t;
  endfunction

  task automatic cmp_words(input string name);
    chk({name, "_cnt"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", name, i), got[i], exp_w[i]);
  endtask

  initial begin
    int nvalid;
    int pv;
    int pr;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Two frames with ready held high, second header carries frame count 1.
    tbl.push_back(mk(1'b1, 32'd1,  1'b1, 1'b0, 32'd0, 1'b0, 4'd1));
    tbl.push_back(mk(1'b1, 32'd2,  1'b1, 1'b0, 32'd0, 1'b0, 4'd2));
    tbl.push_back(mk(1'b1, 32'd3,  1'b1, 1'b0, 32'd0, 1'b0, 4'd3));
    tbl.push_back(mk(1'b1, 32'd4,  1'b1, 1'b0, 32'd0, 1'b0, 4'd4));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'hA55A0000, 1'b0, 4'd4));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd1, 1'b0, 4'd4));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd2, 1'b0, 4'd3));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd3, 1'b0, 4'd2));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd4, 1'b0, 4'd1));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'h00000004, 1'b1, 4'd0));
    tbl.push_back(mk(1'b1, 32'd9,  1'b1, 1'b0, 32'd0, 1'b0, 4'd1));
    tbl.push_back(mk(1'b1, 32'd10, 1'b1, 1'b0, 32'd0, 1'b0, 4'd2));
    tbl.push_back(mk(1'b1, 32'd11, 1'b1, 1'b0, 32'd0, 1'b0, 4'd3));
    tbl.push_back(mk(1'b1, 32'd12, 1'b1, 1'b0, 32'd0, 1'b0, 4'd4));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'hA55A0001, 1'b0, 4'd4));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd9, 1'b0, 4'd4));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd10, 1'b0, 4'd3));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd11, 1'b0, 4'd2));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'd12, 1'b0, 4'd1));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b1, 32'h00000004, 1'b1, 4'd0));
    tbl.push_back(mk(1'b0, 32'd0,  1'b1, 1'b0, 32'd0, 1'b0, 4'd0));

    @(negedge clk);
    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      cyc(tbl[r].iv, tbl[r].id, tbl[r].rdy);
      chk($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_last", r), 32'(out_last), 32'(tbl[r].el));
      chk($sformatf("tbl%0d_level", r), 32'(fifo_level), 32'(tbl[r].elv));
      if (tbl[r].ev) chk($sformatf("tbl%0d_data", r), out_data, tbl[r].ed);
    end

    // Overflow while stalled, then two back-to-back frames once ready rises.
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, 32'hA55A0000);
      chk("stall_last", 32'(out_last), 32'd0);
      cyc(1'b0, 32'd0, 1'b0);
    end
    exp_w = '{32'hA55A0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4,
              32'hA55A0001, 32'd5, 32'd6, 32'd7, 32'd8, 32'h0000000C};
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b_data%0d", i), out_data, exp_w[i]);
      chk($sformatf("b2b_last%0d", i), 32'(out_last), 32'(i == 5 || i == 11));
      cyc(1'b0, 32'd0, 1'b1);
    end
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Ready toggling: every word held exactly two cycles.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(10 * (i + 1)), 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    nvalid = 0;
    got.delete();
    for (int k = 0; k < 14; k++) begin
      if (out_valid) nvalid++;
      if (out_valid && (k % 2 == 1)) got.push_back(out_data);
      cyc(1'b0, 32'd0, logic'(k % 2 == 1));
    end
    chk("toggle_valid_cycles", 32'(nvalid), 32'd12);
    exp_w = '{32'hA55A0000, 32'd10, 32'd20, 32'd30, 32'd40, 32'h00000028};
    cmp_words("toggle");

    // Reset mid-frame after the second payload word.
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 5; i <= 8; i++) cyc(1'b1, 32'(i), 1'b1);
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (out_valid) got.push_back(out_data);
      cyc(1'b0, 32'd0, 1'b1);
    end
    exp_w = '{32'hA55A0000, 32'd5, 32'd6, 32'd7, 32'd8, 32'h0000000C};
    cmp_words("midrst");

    // Overflow counter saturation.
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 32'(i), 1'b0);
    force dut.ovf_cnt = 16'hFFFE;
    #1;
    release dut.ovf_cnt;
    m_ovf = 16'hFFFE;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hDEAD0000, 1'b0);
    chk("ovf_sat", 32'(ovf_cnt), 32'h0000FFFF);
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'hBEEF0000, 1'b0);
    chk("ovf_hold", 32'(ovf_cnt), 32'h0000FFFF);

    // Random traffic under varying load and back-pressure.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      pv = (ph == 0) ? 60 : (ph == 1) ? 80 : (ph == 2) ? 95 : 30;
      pr = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 10 : 100;
      for (int c = 0; c < 250; c++)
        cyc(logic'($urandom_range(99) < pv), $urandom, logic'($urandom_range(99) < pr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
